serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor that computes A − B − Bin one bit per clock, LSB first. Each bit step uses the same difference/borrow equations as the full-subtractor cell. The block sits directly upstream of the switch/LED display logic on the Basys3 board. It replaces a ripple chain of full-subtractor cells with one cell plus a borrow register and shift registers, under a start/busy/done handshake.

---
 rtl/serial_subtractor.sv | 135 +++++++++++++
 tb/tb_serial_subtractor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial subtractor: computes (a - b - bin) one bit per clock, LSB first,
// using a single full-subtractor cell, a borrow register and shift registers.
// A start/busy/done handshake frames each operation. An operation takes
// WIDTH+2 cycles from one accept to the next.
//
// Ports:
//   clk    - system clock, rising-edge active
//   rst    - synchronous reset, active-high, priority over everything
//   start  - request a subtraction; only looked at while idle
//   a, b   - minuend / subtrahend, captured on an accepted start
//   bin    - borrow-in, captured on an accepted start
//   busy   - high while bits are being shifted through the cell
//   done   - one-cycle pulse when diff/bout/ovf take a new result
//   diff   - (a - b - bin) mod 2^WIDTH, held until the next done
//   bout   - final borrow-out (unsigned a < b + bin)
//   ovf    - two's-complement overflow of a - b - bin
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;
    logic             borrow_reg;
    logic [CW-1:0]    count_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             ovf_reg;

    // Single full-subtractor cell operating on the current LSBs.
    logic             d_bit;
    logic             borrow_next;
    logic [WIDTH-1:0] res_next;

    assign d_bit       = a_sh_reg[0] ^ b_sh_reg[0] ^ borrow_reg;
    assign borrow_next = (~a_sh_reg[0] & b_sh_reg[0])
                       | (~(a_sh_reg[0] ^ b_sh_reg[0]) & borrow_reg);

    // The new difference bit enters at the MSB; after WIDTH steps the first
    // (LSB) bit has walked all the way down to bit 0.
    assign res_next = {d_bit, res_reg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_reg    <= '0;
            borrow_reg <= 1'b0;
            count_reg  <= '0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg   <= a;
                        b_sh_reg   <= b;
                        res_reg    <= '0;
                        borrow_reg <= bin;
                        count_reg  <= '0;
                        a_msb_reg  <= a[WIDTH-1];
                        b_msb_reg  <= b[WIDTH-1];
                        busy_reg   <= 1'b1;
                        state_reg  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    res_reg    <= res_next;
                    borrow_reg <= borrow_next;
                    count_reg  <= count_reg + 1'b1;
                    if (count_reg == LAST_BIT) begin
                        // Last bit: publish the result in the same edge.
                        // d_bit here is the result's sign bit.
                        diff_reg  <= res_next;
                        bout_reg  <= borrow_next;
                        ovf_reg   <= (a_msb_reg != b_msb_reg) && (d_bit != a_msb_reg);
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign diff = diff_reg;
    assign bout = bout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed cases with literal expectations
// plus a randomized run, all compared every cycle against an arithmetic
// model of the result and of the handshake timing.
module tb_serial_subtractor;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Plain-arithmetic reference: {diff, bout, ovf}.
    function automatic logic [W+1:0] ref_sub(input int av, input int bv, input int bi);
        int u, sa, sb, s;
        logic [W-1:0] dd;
        u  = av - bv - bi;
        dd = W'(u & MASK);
        sa = (av >= HALF) ? av - (1 << W) : av;
        sb = (bv >= HALF) ? bv - (1 << W) : bv;
        s  = sa - sb - bi;
        return {dd, (u < 0), (s < -HALF || s > HALF - 1)};
    endfunction

    // Timing model: phase 0 idle, 1..W busy, W+1 done.
    int           m_ph   = 0;
    logic [W+1:0] m_pend = '0;
    logic [W+1:0] m_out  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph  = 0;
            m_out = '0;
        end else if (m_ph == 0) begin
            if (start) begin
                m_pend = ref_sub(int'(a), int'(b), int'(bin));
                m_ph   = 1;
            end
        end else if (m_ph < W) begin
            m_ph = m_ph + 1;
        end else if (m_ph == W) begin
            m_out = m_pend;
            m_ph  = W + 1;
        end else begin
            m_ph = 0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [W+3:0] got, exp;
        got = {busy, done, diff, bout, ovf};
        exp = {(m_ph >= 1 && m_ph <= W), (m_ph == W + 1), m_out};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cycle_model t=%0t got busy=%b done=%b diff=%h bout=%b ovf=%b required busy=%b done=%b diff=%h bout=%b ovf=%b",
                     $time, busy, done, diff, bout, ovf, exp[W+3], exp[W+2], exp[W+1:2], exp[1], exp[0]);
        end
    end

    task automatic check_val(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end else begin
            $display("ok   %s value=%0h", name, got);
        end
    endtask

    // Waits (bounded) for a done pulse; returns negedges elapsed, or -1.
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
        end
        if (cycles < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got=no_done required=done_within_30");
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input int e_diff, input int e_bout, input int e_ovf);
        int n;
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~av;  // operands may change after capture
        check_val({name, "_busy"}, int'(busy), 1);
        wait_done(n);
        check_val({name, "_latency"}, n, W);
        check_val({name, "_diff"}, int'(diff), e_diff);
        check_val({name, "_bout"}, int'(bout), e_bout);
        check_val({name, "_ovf"}, int'(ovf), e_ovf);
    endtask

    initial begin
        int n;

        // Pin the reference model itself with hand-worked values.
        check_val("model_10_3",   int'(ref_sub(10, 3, 0)),     (8'h07 << 2) | 0);
        check_val("model_3_10",   int'(ref_sub(3, 10, 0)),     (8'hF9 << 2) | 2);
        check_val("model_80_01",  int'(ref_sub(8'h80, 1, 0)),  (8'h7F << 2) | 1);
        check_val("model_5_5_b1", int'(ref_sub(5, 5, 1)),      (8'hFF << 2) | 2);

        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_val("reset_outputs", int'({busy, done, diff, bout, ovf}), 0);

        // Directed arithmetic cases.
        run_op("basic",     8'd10,  8'd3,   1'b0, 8'h07, 0, 0);
        run_op("wrap",      8'd3,   8'd10,  1'b0, 8'hF9, 1, 0);
        run_op("ovf_neg",   8'h80,  8'h01,  1'b0, 8'h7F, 0, 1);
        run_op("ovf_pos",   8'h7F,  8'hFF,  1'b0, 8'h80, 1, 1);
        run_op("borrow_in", 8'd5,   8'd5,   1'b1, 8'hFF, 1, 0);

        // Handshake: start held high, operand changed mid-shift.
        @(negedge clk);
        a = 8'd20; b = 8'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'd99;
        wait_done(n);
        check_val("hold_first_diff", int'(diff), 19);
        wait_done(n);
        check_val("hold_period1", n, W + 2);
        check_val("hold_second_diff", int'(diff), 98);
        wait_done(n);
        check_val("hold_period2", n, W + 2);
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        check_val("hold_released_idle", int'(busy), 0);

        // Reset in the 4th shift cycle aborts the operation.
        a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_outputs", int'({busy, done, diff, bout, ovf}), 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check_val("abort_no_done", n, 0);
        run_op("after_abort", 8'hAA, 8'h55, 1'b0, 8'h55, 0, 1);

        // Randomized traffic, including start during busy and rare resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
            start = ($urandom_range(0, 2) != 0);
            rst   = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
